// File: rtl/cpu_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding, owner ids and bus width defaults.
package cpu_pkg;

   localparam int unsigned ADDR_W_DEF = 64;
   localparam int unsigned DATA_W_DEF = 64;
   localparam int unsigned CNT_W      = 4;

   localparam logic OWN_CPU = 1'b0;
   localparam logic OWN_DBG = 1'b1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_RESP = 2'd2
   } state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to whoever was not served last.
module rr_arbiter2
   import cpu_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_owner,
   output logic       gnt_valid_c,
   output logic       gnt_owner_c
);

   always_comb begin
      gnt_valid_c = |req;
      gnt_owner_c = OWN_CPU;
      case (req)
         2'b01:   gnt_owner_c = OWN_CPU;
         2'b10:   gnt_owner_c = OWN_DBG;
         2'b11:   gnt_owner_c = ~last_owner;
         default: gnt_owner_c = OWN_CPU;
      endcase
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one multi-cycle data-memory port between the CPU load/store path and a debug port,
// stalling the CPU until its own access completes.
module dmem_arbiter
   import cpu_pkg::*;
#(
   parameter int unsigned ADDR_W      = ADDR_W_DEF,
   parameter int unsigned DATA_W      = DATA_W_DEF,
   parameter int unsigned MEM_LATENCY = 2
) (
   input  logic              CLOCK,
   input  logic              RESET_N,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_stall,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   output logic              dbg_ack,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'(7);
   localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(MEM_LATENCY - 1);

   state_e              state_q, state_d;
   logic                owner_q, owner_d;
   logic                last_owner_q, last_owner_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                mem_en_q, mem_en_d;
   logic                mem_we_q, mem_we_d;
   logic                dbg_ack_q, dbg_ack_d;

   logic                gnt_valid_c;
   logic                gnt_owner_c;

   rr_arbiter2 u_rr (
      .req         ({dbg_req, cpu_req}),
      .last_owner  (last_owner_q),
      .gnt_valid_c (gnt_valid_c),
      .gnt_owner_c (gnt_owner_c)
   );

   // Next-state, request latching and registered memory-side controls.
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      cnt_d        = cnt_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      rdata_d      = rdata_q;

      case (state_q)
         S_IDLE: begin
            if (gnt_valid_c) begin
               owner_d = gnt_owner_c;
               cnt_d   = CNT_LOAD;
               state_d = S_BUSY;
               if (gnt_owner_c == OWN_DBG) begin
                  we_d    = dbg_we;
                  addr_d  = dbg_addr & ADDR_MASK;
                  wdata_d = dbg_wdata;
               end else begin
                  we_d    = cpu_we;
                  addr_d  = cpu_addr & ADDR_MASK;
                  wdata_d = cpu_wdata;
               end
            end
         end
         S_BUSY: begin
            if (cnt_q == '0) begin
               if (!we_q) begin
                  rdata_d = mem_rdata;
               end
               last_owner_d = owner_q;
               state_d      = S_RESP;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Memory controls follow the state being entered so they are flop outputs.
      mem_en_d  = (state_d == S_BUSY);
      mem_we_d  = (state_d == S_BUSY) && we_d;
      dbg_ack_d = (state_d == S_RESP) && (owner_d == OWN_DBG);
   end

   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q      <= S_IDLE;
         owner_q      <= OWN_CPU;
         last_owner_q <= OWN_DBG;
         cnt_q        <= '0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         rdata_q      <= '0;
         mem_en_q     <= 1'b0;
         mem_we_q     <= 1'b0;
         dbg_ack_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         cnt_q        <= cnt_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         rdata_q      <= rdata_d;
         mem_en_q     <= mem_en_d;
         mem_we_q     <= mem_we_d;
         dbg_ack_q    <= dbg_ack_d;
      end
   end

   // The CPU is released only in the response cycle of its own access.
   assign cpu_stall = cpu_req & ~((state_q == S_RESP) & (owner_q == OWN_CPU));

   assign cpu_rdata = rdata_q;
   assign dbg_rdata = rdata_q;
   assign dbg_ack   = dbg_ack_q;
   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: per-cycle vector table on a MEM_LATENCY=2 and a MEM_LATENCY=1
// instance, plus a hand-written reset-during-access sequence.
module tb_dmem_arbiter;

   localparam logic [63:0] Z = 64'h0;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n2, rst_n1, dsel, preload;
   logic        cpu_req, cpu_we, dbg_req, dbg_we;
   logic [63:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;

   logic        stall2, ack2, en2, we2, stall1, ack1, en1, we1;
   logic [63:0] crd2, drd2, addr2, wdata2, rdata2;
   logic [63:0] crd1, drd1, addr1, wdata1, rdata1;
   logic [63:0] mem2 [16];
   logic [63:0] mem1 [16];

   logic        o_stall, o_ack, o_en, o_we;
   logic [63:0] o_crd, o_drd, o_addr, o_wdata;

   int checks   = 0;
   int failures = 0;

   dmem_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LATENCY(2)) u_dut2 (
      .CLOCK(clk), .RESET_N(rst_n2),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_stall(stall2), .cpu_rdata(crd2),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_ack(ack2), .dbg_rdata(drd2),
      .mem_en(en2), .mem_we(we2), .mem_addr(addr2), .mem_wdata(wdata2), .mem_rdata(rdata2)
   );

   dmem_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LATENCY(1)) u_dut1 (
      .CLOCK(clk), .RESET_N(rst_n1),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_stall(stall1), .cpu_rdata(crd1),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_ack(ack1), .dbg_rdata(drd1),
      .mem_en(en1), .mem_we(we1), .mem_addr(addr1), .mem_wdata(wdata1), .mem_rdata(rdata1)
   );

   // Memory models: 16 doublewords each, read data valid while mem_en is held.
   assign rdata2 = en2 ? mem2[addr2[6:3]] : Z;
   assign rdata1 = en1 ? mem1[addr1[6:3]] : Z;

   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 16; i++) begin
            mem2[i] <= Z;
            mem1[i] <= Z;
         end
         mem2[2] <= 64'hDEAD;
         mem2[3] <= 64'h1111;
      end else begin
         if (en2 && we2) mem2[addr2[6:3]] <= wdata2;
         if (en1 && we1) mem1[addr1[6:3]] <= wdata1;
      end
   end

   always_comb begin
      if (dsel) begin
         o_stall = stall1; o_ack = ack1; o_en = en1; o_we = we1;
         o_crd = crd1; o_drd = drd1; o_addr = addr1; o_wdata = wdata1;
      end else begin
         o_stall = stall2; o_ack = ack2; o_en = en2; o_we = we2;
         o_crd = crd2; o_drd = drd2; o_addr = addr2; o_wdata = wdata2;
      end
   end

   typedef struct {
      logic [1:0]  cpu;     // {req, we}
      logic [63:0] ca, cd;
      logic [1:0]  dbg;     // {req, we}
      logic [63:0] da, dd;
      logic [3:0]  ex;      // {cpu_stall, mem_en, mem_we, dbg_ack}
      logic        chk_a;
      logic [63:0] ea, ew;
      logic [1:0]  rsel;    // 1: cpu_rdata, 2: dbg_rdata
      logic [63:0] er;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic [1:0] c, input logic [63:0] ca, input logic [63:0] cd,
                               input logic [1:0] d, input logic [63:0] da, input logic [63:0] dd,
                               input logic [3:0] ex, input logic ck, input logic [63:0] ea,
                               input logic [63:0] ew, input logic [1:0] rs, input logic [63:0] er);
      vec_t v;
      v.cpu = c;  v.ca = ca; v.cd = cd;
      v.dbg = d;  v.da = da; v.dd = dd;
      v.ex = ex;  v.chk_a = ck; v.ea = ea; v.ew = ew;
      v.rsel = rs; v.er = er;
      return v;
   endfunction

   task automatic chk1(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %b expected %b", nm, act, exp);
      end
   endtask

   task automatic chk64(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic apply(input vec_t v);
      cpu_req = v.cpu[1]; cpu_we = v.cpu[0]; cpu_addr = v.ca; cpu_wdata = v.cd;
      dbg_req = v.dbg[1]; dbg_we = v.dbg[0]; dbg_addr = v.da; dbg_wdata = v.dd;
   endtask

   task automatic run_rows(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         @(posedge clk); #1;
         apply(tbl[i]);
         @(negedge clk);
         chk1($sformatf("row%0d cpu_stall", i), o_stall, tbl[i].ex[3]);
         chk1($sformatf("row%0d mem_en", i),    o_en,    tbl[i].ex[2]);
         chk1($sformatf("row%0d mem_we", i),    o_we,    tbl[i].ex[1]);
         chk1($sformatf("row%0d dbg_ack", i),   o_ack,   tbl[i].ex[0]);
         if (tbl[i].chk_a) begin
            chk64($sformatf("row%0d mem_addr", i),  o_addr,  tbl[i].ea);
            chk64($sformatf("row%0d mem_wdata", i), o_wdata, tbl[i].ew);
         end
         if (tbl[i].rsel == 2'd1) chk64($sformatf("row%0d cpu_rdata", i), o_crd, tbl[i].er);
         if (tbl[i].rsel == 2'd2) chk64($sformatf("row%0d dbg_rdata", i), o_drd, tbl[i].er);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int  n;
      logic got;

      // MEM_LATENCY=2: CPU load, DBG misaligned write, contended round-robin with mid-access input changes
      tbl.push_back(mk(2'b10, 64'h10, Z, 2'b00, Z, Z, 4'b1000, 1'b0, Z, Z, 2'd0, Z));            // 0
      tbl.push_back(mk(2'b10, 64'h10, Z, 2'b00, Z, Z, 4'b1100, 1'b1, 64'h10, Z, 2'd0, Z));       // 1
      tbl.push_back(mk(2'b10, 64'h10, Z, 2'b00, Z, Z, 4'b1100, 1'b1, 64'h10, Z, 2'd0, Z));       // 2
      tbl.push_back(mk(2'b10, 64'h10, Z, 2'b00, Z, Z, 4'b0000, 1'b0, Z, Z, 2'd1, 64'hDEAD));     // 3
      tbl.push_back(mk(2'b00, Z, Z, 2'b00, Z, Z, 4'b0000, 1'b0, Z, Z, 2'd0, Z));                 // 4
      tbl.push_back(mk(2'b00, Z, Z, 2'b11, 64'h1F, 64'h55, 4'b0000, 1'b0, Z, Z, 2'd0, Z));       // 5
      tbl.push_back(mk(2'b00, Z, Z, 2'b11, 64'h1F, 64'h55, 4'b0110, 1'b1, 64'h18, 64'h55, 2'd0, Z)); // 6
      tbl.push_back(mk(2'b00, Z, Z, 2'b11, 64'h1F, 64'h55, 4'b0110, 1'b1, 64'h18, 64'h55, 2'd0, Z)); // 7
      tbl.push_back(mk(2'b00, Z, Z, 2'b11, 64'h1F, 64'h55, 4'b0001, 1'b0, Z, Z, 2'd0, Z));       // 8
      tbl.push_back(mk(2'b00, Z, Z, 2'b00, Z, Z, 4'b0000, 1'b0, Z, Z, 2'd0, Z));                 // 9
      tbl.push_back(mk(2'b11, 64'h20, 64'h77, 2'b10, 64'h18, Z, 4'b1000, 1'b0, Z, Z, 2'd0, Z));  // 10
      tbl.push_back(mk(2'b11, 64'h20, 64'h77, 2'b10, 64'h18, Z, 4'b1110, 1'b1, 64'h20, 64'h77, 2'd0, Z)); // 11
      tbl.push_back(mk(2'b11, 64'h48, 64'h88, 2'b10, 64'h18, Z, 4'b1110, 1'b1, 64'h20, 64'h77, 2'd0, Z)); // 12
      tbl.push_back(mk(2'b11, 64'h48, 64'h88, 2'b10, 64'h18, Z, 4'b0000, 1'b0, Z, Z, 2'd0, Z));  // 13
      tbl.push_back(mk(2'b11, 64'h48, 64'h88, 2'b10, 64'h18, Z, 4'b1000, 1'b0, Z, Z, 2'd0, Z));  // 14
      tbl.push_back(mk(2'b11, 64'h48, 64'h88, 2'b10, 64'h18, Z, 4'b1100, 1'b1, 64'h18, Z, 2'd0, Z)); // 15
      tbl.push_back(mk(2'b11, 64'h48, 64'h88, 2'b10, 64'h18, Z, 4'b1100, 1'b1, 64'h18, Z, 2'd0, Z)); // 16
      tbl.push_back(mk(2'b11, 64'h48, 64'h88, 2'b10, 64'h18, Z, 4'b1001, 1'b0, Z, Z, 2'd2, 64'h55)); // 17
      tbl.push_back(mk(2'b11, 64'h48, 64'h88, 2'b10, 64'h18, Z, 4'b1000, 1'b0, Z, Z, 2'd0, Z));  // 18
      tbl.push_back(mk(2'b11, 64'h48, 64'h88, 2'b10, 64'h18, Z, 4'b1110, 1'b1, 64'h48, 64'h88, 2'd0, Z)); // 19
      tbl.push_back(mk(2'b11, 64'h48, 64'h88, 2'b10, 64'h18, Z, 4'b1110, 1'b1, 64'h48, 64'h88, 2'd0, Z)); // 20
      tbl.push_back(mk(2'b11, 64'h48, 64'h88, 2'b10, 64'h18, Z, 4'b0000, 1'b0, Z, Z, 2'd0, Z));  // 21
      tbl.push_back(mk(2'b00, Z, Z, 2'b10, 64'h18, Z, 4'b0000, 1'b0, Z, Z, 2'd0, Z));            // 22
      tbl.push_back(mk(2'b00, Z, Z, 2'b10, 64'h18, Z, 4'b0100, 1'b1, 64'h18, Z, 2'd0, Z));       // 23
      tbl.push_back(mk(2'b00, Z, Z, 2'b10, 64'h18, Z, 4'b0100, 1'b1, 64'h18, Z, 2'd0, Z));       // 24
      tbl.push_back(mk(2'b00, Z, Z, 2'b10, 64'h18, Z, 4'b0001, 1'b0, Z, Z, 2'd2, 64'h55));       // 25
      tbl.push_back(mk(2'b00, Z, Z, 2'b00, Z, Z, 4'b0000, 1'b0, Z, Z, 2'd0, Z));                 // 26
      // MEM_LATENCY=1: CPU store then DBG read-back of the same doubleword
      tbl.push_back(mk(2'b11, 64'h30, 64'hCAFE, 2'b10, 64'h30, Z, 4'b1000, 1'b0, Z, Z, 2'd0, Z)); // 27
      tbl.push_back(mk(2'b11, 64'h30, 64'hCAFE, 2'b10, 64'h30, Z, 4'b1110, 1'b1, 64'h30, 64'hCAFE, 2'd0, Z)); // 28
      tbl.push_back(mk(2'b11, 64'h30, 64'hCAFE, 2'b10, 64'h30, Z, 4'b0000, 1'b0, Z, Z, 2'd0, Z)); // 29
      tbl.push_back(mk(2'b00, Z, Z, 2'b10, 64'h30, Z, 4'b0000, 1'b0, Z, Z, 2'd0, Z));            // 30
      tbl.push_back(mk(2'b00, Z, Z, 2'b10, 64'h30, Z, 4'b0100, 1'b1, 64'h30, Z, 2'd0, Z));       // 31
      tbl.push_back(mk(2'b00, Z, Z, 2'b10, 64'h30, Z, 4'b0001, 1'b0, Z, Z, 2'd2, 64'hCAFE));     // 32
      tbl.push_back(mk(2'b00, Z, Z, 2'b00, Z, Z, 4'b0000, 1'b0, Z, Z, 2'd0, Z));                 // 33

      dsel = 1'b0; preload = 1'b1; rst_n2 = 1'b0; rst_n1 = 1'b0;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = Z; cpu_wdata = Z;
      dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = Z; dbg_wdata = Z;
      repeat (2) @(negedge clk);

      chk1 ("reset mem_en",    o_en,   1'b0);
      chk1 ("reset mem_we",    o_we,   1'b0);
      chk1 ("reset dbg_ack",   o_ack,  1'b0);
      chk64("reset mem_addr",  o_addr, Z);
      chk64("reset mem_wdata", o_wdata, Z);
      chk64("reset cpu_rdata", o_crd,  Z);
      chk64("reset dbg_rdata", o_drd,  Z);
      chk1 ("reset stall idle", o_stall, 1'b0);
      cpu_req = 1'b1; #1;
      chk1 ("reset stall req", o_stall, 1'b1);
      cpu_req = 1'b0;
      preload = 1'b0;
      rst_n2  = 1'b1;

      run_rows(0, 26);

      // Reset pulled during the second BUSY cycle of a CPU load.
      @(posedge clk); #1;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 64'h10; cpu_wdata = Z;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      chk1("rst busy2 mem_en", o_en, 1'b1);
      rst_n2 = 1'b0; #1;
      chk1 ("rst mem_en drops", o_en,    1'b0);
      chk1 ("rst stall held",   o_stall, 1'b1);
      chk1 ("rst no ack",       o_ack,   1'b0);
      chk64("rst cpu_rdata",    o_crd,   Z);
      @(negedge clk);
      chk1("rst held mem_en", o_en,  1'b0);
      chk1("rst held no ack", o_ack, 1'b0);
      rst_n2  = 1'b1;
      cpu_req = 1'b0;
      @(posedge clk); #1;
      dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 64'h18; dbg_wdata = Z;
      n = 0; got = 1'b0;
      for (int k = 0; k < 8 && !got; k++) begin
         @(negedge clk);
         if (o_ack) got = 1'b1;
         else n++;
      end
      chk1 ("rst recover ack seen", got, 1'b1);
      chk64("rst recover latency", 64'(n), 64'd3);
      chk64("rst recover dbg_rdata", o_drd, 64'h55);
      @(posedge clk); #1;
      dbg_req = 1'b0;
      @(negedge clk);
      chk1("rst recover ack one cycle", o_ack, 1'b0);

      // Switch to the MEM_LATENCY=1 instance.
      rst_n2 = 1'b0;
      rst_n1 = 1'b1;
      dsel   = 1'b1;
      run_rows(27, 33);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Sequences and shares the single data-memory port between two requesters: the CPU load/store path (MEMREAD/MEMWRITE, ALU result address, REG_DATA2 store data) and a debug/loader port.
- Data memory is modelled with a fixed multi-cycle read/write latency.
- The block arbitrates round-robin, holds the winning request stable at the memory for the full latency, and returns read data.
- It freezes the single-cycle CPU through cpu_stall until that CPU's access completes.

Parameters:
- ADDR_W, 64, address width.
- DATA_W, 64, data width.
- MEM_LATENCY, 2, cycles the memory needs mem_en held before mem_rdata is valid; legal range 1..15.

Ports:
- CLOCK  in  1  system clock, rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU access request (MEMREAD|MEMWRITE); held until served.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_addr  in  ADDR_W  CPU byte address.
- cpu_wdata  in  DATA_W  CPU store data.
- cpu_stall  out  1  freeze PC/regfile write while 1.
- cpu_rdata  out  DATA_W  load data, valid in the cycle cpu_stall drops.
- dbg_req  in  1  debug request; held until dbg_ack.
- dbg_we  in  1  1 = write, 0 = read.
- dbg_addr  in  ADDR_W  debug byte address.
- dbg_wdata  in  DATA_W  debug write data.
- dbg_ack  out  1  one-cycle completion pulse.
- dbg_rdata  out  DATA_W  read data, valid while dbg_ack=1.
- mem_en  out  1  memory access enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  doubleword address; bits [2:0] are forced to 0.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.

Behaviour:
- FSM states: IDLE, BUSY, RESP. Registers:
  - owner (0=CPU, 1=DBG)
  - last_owner
  - cnt (4 bits)
  - latched we/addr/wdata
  - rdata_q
- Reset (async, RESET_N=0) sets:
  - state=IDLE, owner=0, last_owner=1 (CPU wins the first tie), cnt=0, rdata_q=0
  - mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, dbg_ack=0, dbg_rdata=0, cpu_rdata=0
  - cpu_stall is combinational: it is 1 whenever cpu_req=1, including during reset.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant it.
  - Both requesting: grant the requester that is not last_owner.
  - On grant: latch we/addr/wdata of the winner, set owner, cnt=MEM_LATENCY-1, go to BUSY.
- BUSY:
  - mem_en=1; mem_we/mem_addr/mem_wdata driven from the latched values and stable for all MEM_LATENCY cycles.
  - When cnt==0: capture rdata_q<=mem_rdata (loads only; stores leave rdata_q unchanged), last_owner<=owner, go to RESP.
  - Otherwise cnt decrements.
- RESP (exactly 1 cycle):
  - mem_en=0.
  - owner=DBG: dbg_ack=1, dbg_rdata=rdata_q.
  - owner=CPU: cpu_stall=0, cpu_rdata=rdata_q.
  - Next state: IDLE.
- cpu_stall = cpu_req AND NOT (state==RESP AND owner==CPU).
- Latency:
  - Single access from request in IDLE to completion: MEM_LATENCY+1 cycles.
  - Back-to-back accesses: MEM_LATENCY+2 cycles each, because RESP→IDLE adds one arbitration bubble.
- Round-robin guarantee: with both requesters continuously asserting, grants alternate CPU, DBG, CPU, ...
- Request dropped mid-BUSY: the access still completes and the ack/unstall is issued and ignored; writes are not cancelled.
- Request inputs changing during BUSY have no effect, because the latched copy is used.
- Misaligned address: low 3 bits are masked and no error is raised.
- Reset asserted mid-BUSY: FSM immediately returns to IDLE, mem_en drops asynchronously, and no ack is issued. A partial memory write is the memory's responsibility.
- MEM_LATENCY=1: BUSY lasts exactly one cycle.

Decomposition:
- Shared package cpu_pkg holds:
  - state encoding localparams: S_IDLE=2'd0, S_BUSY=2'd1, S_RESP=2'd2
  - owner constants: OWN_CPU=1'b0, OWN_DBG=1'b1
  - DATA_W/ADDR_W defaults
- One natural sub-module: rr_arbiter2 (2-way round-robin grant from req[1:0] and last_owner; combinational). The FSM, counter and latches stay in dmem_arbiter.

Test Plan:
- Reset then CPU load, MEM_LATENCY=2, cpu_addr=0x10, mem_rdata=0xDEAD → cpu_stall=1 for 3 cycles, mem_en high for 2 cycles, cpu_rdata=0xDEAD in the unstall cycle.
- CPU and DBG requests in the same cycle after reset, both held → grant order CPU, DBG, CPU, DBG, each served in MEM_LATENCY+2 cycles; dbg_ack pulses exactly 1 cycle.
- DBG write addr=0x1F, wdata=0x55 → mem_addr=0x18, mem_we=1, mem_wdata=0x55 held for MEM_LATENCY cycles; dbg_ack then 1.
- Change cpu_addr and cpu_wdata during BUSY → mem_addr and mem_wdata stay at the latched values.
- Pull RESET_N low during the second BUSY cycle → mem_en=0 immediately, state IDLE, no ack; after release a new request is served normally.
- MEM_LATENCY=1 build, CPU store then DBG read back-to-back → each completes in 3 cycles; dbg_rdata equals the value the memory model returns for that address.
